junction_controller: RTL and testbench

Two-road junction scheduler that shares the crossing between the north-south (NS) road, the east-west (EW) road and a pedestrian crossing. Each road runs the standard light sequence: red, red+amber, green, amber, red. An all-red interval separates every hand-over, and a round-robin arbiter picks the next phase from latched requests. It sits above the single-road light sequencer and drives the lamp outputs for both roads plus the walk signal.

---
 rtl/junction_pkg.sv | 63 ++++++
 rtl/phase_timer.sv | 38 +++
 rtl/junction_controller.sv | 159 +++++++++++++++
 tb/tb_junction_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/junction_pkg.sv
// Shared types and defaults for the two-road junction scheduler.
// Lamp triples are {green, amber, red}, the same bit order as the single-road sequencer.
package junction_pkg;

    typedef enum logic [3:0] {
        ST_ALLRED_IDLE,
        ST_ALLRED,
        ST_NS_RA,
        ST_NS_G,
        ST_NS_A,
        ST_EW_RA,
        ST_EW_G,
        ST_EW_A,
        ST_PED_WALK
    } state_e;

    typedef enum logic [1:0] {
        PH_NS,
        PH_EW,
        PH_PED
    } phase_e;

    typedef struct packed {
        logic   valid;
        phase_e phase;
    } grant_t;

    localparam int unsigned T_RA_DEF     = 2;
    localparam int unsigned T_AMBER_DEF  = 3;
    localparam int unsigned T_ALLRED_DEF = 2;
    localparam int unsigned T_GMIN_DEF   = 5;
    localparam int unsigned T_GMAX_DEF   = 20;
    localparam int unsigned T_WALK_DEF   = 8;
    localparam int unsigned CNT_W_DEF    = 5;

    localparam logic [2:0] LAMP_RED       = 3'b001;
    localparam logic [2:0] LAMP_RED_AMBER = 3'b011;
    localparam logic [2:0] LAMP_GREEN     = 3'b100;
    localparam logic [2:0] LAMP_AMBER     = 3'b010;

    function automatic state_e entry_state(phase_e p);
        case (p)
            PH_NS:   return ST_NS_RA;
            PH_EW:   return ST_EW_RA;
            default: return ST_PED_WALK;
        endcase
    endfunction

    // Road lamps depend only on the state; any state not owned by the road shows red.
    function automatic logic [2:0] road_lamp(state_e s, logic is_ns);
        state_e ra;
        state_e g;
        state_e a;
        ra = is_ns ? ST_NS_RA : ST_EW_RA;
        g  = is_ns ? ST_NS_G  : ST_EW_G;
        a  = is_ns ? ST_NS_A  : ST_EW_A;
        if (s == ra)     return LAMP_RED_AMBER;
        else if (s == g) return LAMP_GREEN;
        else if (s == a) return LAMP_AMBER;
        else             return LAMP_RED;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state cycle counter: sync clear, saturating increment, equality compare against a target.
module phase_timer
    import junction_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             at_target
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count     = cnt_q;
    assign at_target = (cnt_q == target);

endmodule

// File: rtl/junction_controller.sv
// Junction scheduler: NS road, EW road and pedestrian crossing share the crossing,
// separated by all-red clearance and chosen round-robin from latched requests.
module junction_controller
    import junction_pkg::*;
#(
    parameter int unsigned T_RA     = T_RA_DEF,
    parameter int unsigned T_AMBER  = T_AMBER_DEF,
    parameter int unsigned T_ALLRED = T_ALLRED_DEF,
    parameter int unsigned T_GMIN   = T_GMIN_DEF,
    parameter int unsigned T_GMAX   = T_GMAX_DEF,
    parameter int unsigned T_WALK   = T_WALK_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_ns,
    input  logic req_ew,
    input  logic req_ped,
    output logic ns_red,
    output logic ns_amber,
    output logic ns_green,
    output logic ew_red,
    output logic ew_amber,
    output logic ew_green,
    output logic walk,
    output logic busy
);

    localparam logic [CNT_W-1:0] RA_M1     = CNT_W'(T_RA - 1);
    localparam logic [CNT_W-1:0] AMBER_M1  = CNT_W'(T_AMBER - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] GMIN_M1   = CNT_W'(T_GMIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1   = CNT_W'(T_GMAX - 1);
    localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(T_WALK - 1);

    state_e           state_q, state_d;
    phase_e           last_q, last_d;
    logic [2:0]       pend_q, pend_d;
    logic [CNT_W-1:0] tgt;
    logic [CNT_W-1:0] count;
    logic             at_target;
    logic             timer_clr;
    logic             ns_leave;
    logic             ew_leave;
    logic             entering;
    grant_t           grant;

    function automatic phase_e rr_next(phase_e p);
        case (p)
            PH_NS:   return PH_EW;
            PH_EW:   return PH_PED;
            default: return PH_NS;
        endcase
    endfunction

    // Search begins at the phase after the one served last.
    function automatic grant_t pick(phase_e last, logic [2:0] pend);
        grant_t g;
        phase_e cand;
        g    = '{valid: 1'b0, phase: PH_NS};
        cand = last;
        for (int unsigned i = 0; i < 3; i++) begin
            cand = rr_next(cand);
            if (!g.valid && pend[cand]) begin
                g.valid = 1'b1;
                g.phase = cand;
            end
        end
        return g;
    endfunction

    always_comb begin
        case (state_q)
            ST_ALLRED:          tgt = ALLRED_M1;
            ST_NS_RA, ST_EW_RA: tgt = RA_M1;
            ST_NS_A, ST_EW_A:   tgt = AMBER_M1;
            ST_PED_WALK:        tgt = WALK_M1;
            default:            tgt = '1;
        endcase
    end

    assign ns_leave = (pend_q[PH_EW] | pend_q[PH_PED]) &&
                      (((count >= GMIN_M1) && !req_ns) || (count >= GMAX_M1));
    assign ew_leave = (pend_q[PH_NS] | pend_q[PH_PED]) &&
                      (((count >= GMIN_M1) && !req_ew) || (count >= GMAX_M1));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant   = pick(last_q, pend_q);
        case (state_q)
            ST_ALLRED_IDLE: begin
                if (grant.valid) begin
                    state_d = entry_state(grant.phase);
                    last_d  = grant.phase;
                end
            end
            ST_ALLRED: begin
                if (at_target) begin
                    if (grant.valid) begin
                        state_d = entry_state(grant.phase);
                        last_d  = grant.phase;
                    end else begin
                        state_d = ST_ALLRED_IDLE;
                    end
                end
            end
            ST_NS_RA:    if (at_target) state_d = ST_NS_G;
            ST_NS_G:     if (ns_leave)  state_d = ST_NS_A;
            ST_NS_A:     if (at_target) state_d = ST_ALLRED;
            ST_EW_RA:    if (at_target) state_d = ST_EW_G;
            ST_EW_G:     if (ew_leave)  state_d = ST_EW_A;
            ST_EW_A:     if (at_target) state_d = ST_ALLRED;
            ST_PED_WALK: if (at_target) state_d = ST_ALLRED;
            default:     state_d = ST_ALLRED;
        endcase

        // A request cannot re-arm its own latch while that phase holds RA/G (or WALK);
        // on the entry edge the clear overrides a simultaneous set.
        pend_d[PH_NS]  = pend_q[PH_NS]  | (req_ns  && !(state_q inside {ST_NS_RA, ST_NS_G}));
        pend_d[PH_EW]  = pend_q[PH_EW]  | (req_ew  && !(state_q inside {ST_EW_RA, ST_EW_G}));
        pend_d[PH_PED] = pend_q[PH_PED] | (req_ped && (state_q != ST_PED_WALK));
        entering = (state_d != state_q) && (state_d inside {ST_NS_RA, ST_EW_RA, ST_PED_WALK});
        if (entering) begin
            pend_d[last_d] = 1'b0;
        end
    end

    assign timer_clr = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ALLRED;
            last_q  <= PH_PED;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (timer_clr),
        .target    (tgt),
        .count     (count),
        .at_target (at_target)
    );

    assign {ns_green, ns_amber, ns_red} = road_lamp(state_q, 1'b1);
    assign {ew_green, ew_amber, ew_red} = road_lamp(state_q, 1'b0);
    assign walk = (state_q == ST_PED_WALK);
    assign busy = (state_q != ST_ALLRED_IDLE);

endmodule

// File: tb/tb_junction_controller.sv
// Bench for junction_controller: vector table through a scoreboard queue, then a random
// sweep with safety invariants and a service-latency bound.
module tb_junction_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_ns = 1'b0;
    logic req_ew = 1'b0;
    logic req_ped = 1'b0;
    logic ns_red, ns_amber, ns_green;
    logic ew_red, ew_amber, ew_green;
    logic walk, busy;

    int checks = 0;
    int errors = 0;
    logic inv_en = 1'b0;

    always #5 clk = ~clk;

    junction_controller #(
        .T_RA     (2),
        .T_AMBER  (3),
        .T_ALLRED (2),
        .T_GMIN   (5),
        .T_GMAX   (20),
        .T_WALK   (8),
        .CNT_W    (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_ns   (req_ns),
        .req_ew   (req_ew),
        .req_ped  (req_ped),
        .ns_red   (ns_red),
        .ns_amber (ns_amber),
        .ns_green (ns_green),
        .ew_red   (ew_red),
        .ew_amber (ew_amber),
        .ew_green (ew_green),
        .walk     (walk),
        .busy     (busy)
    );

    // Output word: {ns_g, ns_a, ns_r, ew_g, ew_a, ew_r, walk, busy}
    localparam logic [7:0] O_IDLE = 8'b001_001_0_0;
    localparam logic [7:0] O_AR   = 8'b001_001_0_1;
    localparam logic [7:0] O_NSRA = 8'b011_001_0_1;
    localparam logic [7:0] O_NSG  = 8'b100_001_0_1;
    localparam logic [7:0] O_NSA  = 8'b010_001_0_1;
    localparam logic [7:0] O_EWRA = 8'b001_011_0_1;
    localparam logic [7:0] O_EWG  = 8'b001_100_0_1;
    localparam logic [7:0] O_EWA  = 8'b001_010_0_1;
    localparam logic [7:0] O_PED  = 8'b001_001_1_1;
    localparam int AGE_MAX = 120;

    typedef struct packed {
        logic       rst;
        logic       rns;
        logic       rew;
        logic       rped;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];

    function automatic void add(int unsigned n, logic rst, logic rn, logic re, logic rp, logic [7:0] e);
        for (int unsigned i = 0; i < n; i++) vecs.push_back({rst, rn, re, rp, e});
    endfunction

    function automatic void preamble();
        add(1, 0, 0, 0, 0, O_AR);
        add(1, 1, 0, 0, 0, O_AR);
        add(1, 1, 0, 0, 0, O_IDLE);
    endfunction

    function automatic logic [7:0] outs();
        return {ns_green, ns_amber, ns_red, ew_green, ew_amber, ew_red, walk, busy};
    endfunction

    function automatic logic legal(logic [2:0] l);
        return (l == 3'b001) || (l == 3'b011) || (l == 3'b100) || (l == 3'b010);
    endfunction

    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            if ((ns_green | ns_amber) && (ew_green | ew_amber)) begin
                errors++;
                $display("FAIL both_roads_active ns=%b ew=%b required at most one active",
                         {ns_green, ns_amber, ns_red}, {ew_green, ew_amber, ew_red});
            end
            checks++;
            if (walk && (ns_green | ns_amber | ew_green | ew_amber)) begin
                errors++;
                $display("FAIL walk_conflict walk=%b ns=%b ew=%b required roads red",
                         walk, {ns_green, ns_amber, ns_red}, {ew_green, ew_amber, ew_red});
            end
            checks++;
            if (!legal({ns_green, ns_amber, ns_red}) || !legal({ew_green, ew_amber, ew_red})) begin
                errors++;
                $display("FAIL lamp_pattern ns=%b ew=%b required R, RA, G or A",
                         {ns_green, ns_amber, ns_red}, {ew_green, ew_amber, ew_red});
            end
        end
    end

    initial begin
        logic [7:0] got;
        logic [7:0] want;
        logic w_ns, w_ew, w_ped;
        int age_ns, age_ew, age_ped;
        logic pre_ns_own, pre_ew_own, pre_ns_ra, pre_ew_ra, pre_walk;

        // 1: reset and idle
        add(2, 0, 0, 0, 0, O_AR);
        add(1, 1, 0, 0, 0, O_AR);
        add(6, 1, 0, 0, 0, O_IDLE);
        // 2: single NS pulse, rest on green
        add(1, 1, 1, 0, 0, O_IDLE);
        add(2, 1, 0, 0, 0, O_NSRA);
        add(10, 1, 0, 0, 0, O_NSG);
        // 3: contention, NS held -> max green; EW then ends at min green
        preamble();
        add(1, 1, 1, 0, 0, O_IDLE);
        add(2, 1, 1, 0, 0, O_NSRA);
        add(2, 1, 1, 0, 0, O_NSG);
        add(1, 1, 1, 1, 0, O_NSG);
        add(17, 1, 1, 0, 0, O_NSG);
        add(3, 1, 1, 0, 0, O_NSA);
        add(2, 1, 1, 0, 0, O_AR);
        add(2, 1, 1, 0, 0, O_EWRA);
        add(5, 1, 1, 0, 0, O_EWG);
        add(3, 1, 1, 0, 0, O_EWA);
        add(2, 1, 1, 0, 0, O_AR);
        add(2, 1, 1, 0, 0, O_NSRA);
        add(6, 1, 0, 0, 0, O_NSG);
        // 4: round robin NS -> EW -> PED
        preamble();
        add(1, 1, 1, 1, 1, O_IDLE);
        add(2, 1, 0, 0, 0, O_NSRA);
        add(5, 1, 0, 0, 0, O_NSG);
        add(3, 1, 0, 0, 0, O_NSA);
        add(2, 1, 0, 0, 0, O_AR);
        add(2, 1, 0, 0, 0, O_EWRA);
        add(5, 1, 0, 0, 0, O_EWG);
        add(3, 1, 0, 0, 0, O_EWA);
        add(2, 1, 0, 0, 0, O_AR);
        add(8, 1, 0, 0, 0, O_PED);
        add(2, 1, 0, 0, 0, O_AR);
        add(3, 1, 0, 0, 0, O_IDLE);
        // 5: reset during EW green with a pending ped request
        preamble();
        add(1, 1, 0, 1, 0, O_IDLE);
        add(2, 1, 0, 0, 0, O_EWRA);
        add(1, 1, 0, 0, 0, O_EWG);
        add(1, 1, 0, 0, 1, O_EWG);
        add(1, 0, 0, 0, 0, O_AR);
        add(1, 1, 0, 0, 0, O_AR);
        add(3, 1, 0, 0, 0, O_IDLE);
        add(1, 1, 1, 1, 0, O_IDLE);
        add(2, 1, 0, 0, 0, O_NSRA);
        add(3, 1, 0, 0, 0, O_NSG);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n   = vecs[i].rst;
            req_ns  = vecs[i].rns;
            req_ew  = vecs[i].rew;
            req_ped = vecs[i].rped;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            want = sb.pop_front();
            got  = outs();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL vec[%0d] lamps got=%b required=%b", i, got, want);
            end
            inv_en = 1'b1;
        end

        // 6: random sweep
        w_ns = 0; w_ew = 0; w_ped = 0;
        age_ns = 0; age_ew = 0; age_ped = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst_n   = 1'b1;
            req_ns  = ($urandom_range(0, 3) == 0);
            req_ew  = ($urandom_range(0, 3) == 0);
            req_ped = ($urandom_range(0, 9) == 0);
            pre_ns_ra  = ns_red & ns_amber;
            pre_ew_ra  = ew_red & ew_amber;
            pre_ns_own = ns_green | pre_ns_ra;
            pre_ew_own = ew_green | pre_ew_ra;
            pre_walk   = walk;
            @(posedge clk);
            #1;
            if (req_ns && !pre_ns_own && !w_ns) begin w_ns = 1; age_ns = 0; end
            if (req_ew && !pre_ew_own && !w_ew) begin w_ew = 1; age_ew = 0; end
            if (req_ped && !pre_walk && !w_ped) begin w_ped = 1; age_ped = 0; end
            if (ns_red && ns_amber && !pre_ns_ra) w_ns = 0;
            if (ew_red && ew_amber && !pre_ew_ra) w_ew = 0;
            if (walk && !pre_walk) w_ped = 0;
            if (w_ns) age_ns++;
            if (w_ew) age_ew++;
            if (w_ped) age_ped++;
            checks++;
            if (age_ns > AGE_MAX || age_ew > AGE_MAX || age_ped > AGE_MAX) begin
                errors++;
                $display("FAIL service_latency cycle=%0d ages ns=%0d ew=%0d ped=%0d required <= %0d",
                         c, age_ns, age_ew, age_ped, AGE_MAX);
                w_ns = 0; w_ew = 0; w_ped = 0;
                age_ns = 0; age_ew = 0; age_ped = 0;
            end
        end

        @(negedge clk);
        inv_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
